ahb_remap_win: RTL and testbench



---
 rtl/ahb_remap_win_pkg.sv | 24 ++
 rtl/ahb_remap_win_if.sv | 30 +++
 rtl/ahb_remap_win_dec.sv | 38 +++
 rtl/ahb_remap_win.sv | 114 +++++++++++
 tb/tb_ahb_remap_win.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_remap_win_pkg.sv
// ahb_remap_pkg: shared constants for the ahb_remap_win bridge.
// Holds the HTRANS codes, the data-phase state encoding and the window-field slicing helpers.
package ahb_remap_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FWD  = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  // Each window occupies one 32-bit slot of the flat BASE/MASK/XLAT vectors.
  localparam int WIN_W = 32;

  function automatic int win_lsb(input int idx);
    return idx * WIN_W;
  endfunction

endpackage

// File: rtl/ahb_remap_win_if.sv
// ahb_remap_win_if: AHB-Lite signal bundle used on both sides of the remap bridge.
// The bridge is a slave on the upstream instance and a master on the downstream one.
interface ahb_remap_win_if #(
  parameter int DW = 32
);
  logic [31:0]   haddr;
  logic [1:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hwrite;
  logic          hmastlock;
  logic          hready;
  logic          hselx;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hresp;
  logic          hreadyout;

  modport slave (
    input  haddr, hsize, hburst, hprot, htrans, hwrite, hmastlock, hready, hselx, hwdata,
    output hrdata, hresp, hreadyout
  );

  modport master (
    output haddr, hsize, hburst, hprot, htrans, hwrite, hmastlock, hwdata,
    input  hrdata, hresp, hready
  );

endinterface

// File: rtl/ahb_remap_win_dec.sv
// ahb_remap_dec: combinational priority window decoder for the remap bridge.
// Lowest-index matching window supplies the translation; a miss passes the address through.
module ahb_remap_dec
  import ahb_remap_pkg::*;
#(
  parameter int                    NWIN     = 2,
  parameter logic [NWIN*WIN_W-1:0] WIN_BASE = {32'h0100_0000, 32'h0000_0000},
  parameter logic [NWIN*WIN_W-1:0] WIN_MASK = {32'hFF00_0000, 32'hFF00_0000},
  parameter logic [NWIN*WIN_W-1:0] WIN_XLAT = {32'h4000_0000, 32'h2000_0000}
) (
  input  logic [31:0] s_haddr,
  output logic        hit,
  output logic [31:0] m_haddr
);

  logic [31:0] base;
  logic [31:0] mask;
  logic [31:0] xlat;

  // Walk from the highest index down so the lowest matching window is applied last and wins.
  always_comb begin
    hit     = 1'b0;
    m_haddr = s_haddr;
    base    = '0;
    mask    = '0;
    xlat    = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      base = WIN_BASE[win_lsb(i) +: WIN_W];
      mask = WIN_MASK[win_lsb(i) +: WIN_W];
      xlat = WIN_XLAT[win_lsb(i) +: WIN_W];
      if ((s_haddr & mask) == (base & mask)) begin
        hit     = 1'b1;
        m_haddr = (s_haddr & ~mask) | (xlat & mask);
      end
    end
  end

endmodule

// File: rtl/ahb_remap_win.sv
// ahb_remap_win: AHB-Lite address-remap bridge with NWIN priority match/mask/translate windows.
// Define AHB_REMAP_WIN_DECERR_EN to answer window misses with a local two-cycle ERROR instead of forwarding.
module ahb_remap_win
  import ahb_remap_pkg::*;
#(
  parameter int                    NWIN     = 2,
  parameter int                    DW       = 32,
  parameter logic [NWIN*WIN_W-1:0] WIN_BASE = {32'h0100_0000, 32'h0000_0000},
  parameter logic [NWIN*WIN_W-1:0] WIN_MASK = {32'hFF00_0000, 32'hFF00_0000},
  parameter logic [NWIN*WIN_W-1:0] WIN_XLAT = {32'h4000_0000, 32'h2000_0000}
) (
  input  logic            hclk,
  input  logic            hresetn,
  ahb_remap_win_if.slave  s_ahb,
  ahb_remap_win_if.master m_ahb
);

  // state   | meaning
  // ST_IDLE | no data phase outstanding
  // ST_FWD  | data phase owned by the downstream slave
  // ST_ERR1 | local ERROR, first cycle (hreadyout low)
  // ST_ERR2 | local ERROR, second cycle; next address phase sampled

  state_t        state_q;
  state_t        state_d;
  state_t        addr_next;
  logic          hit;
  logic          hit_eff;
  logic          addr_valid;
  logic          fwd_en;
  logic [31:0]   haddr_xlat;
  logic [DW-1:0] hrdata_fwd;

  ahb_remap_dec #(
    .NWIN     (NWIN),
    .WIN_BASE (WIN_BASE),
    .WIN_MASK (WIN_MASK),
    .WIN_XLAT (WIN_XLAT)
  ) u_dec (
    .s_haddr (s_ahb.haddr),
    .hit     (hit),
    .m_haddr (haddr_xlat)
  );

`ifdef AHB_REMAP_WIN_DECERR_EN
  assign hit_eff = hit;
`else
  // Without local error decode every selected transfer is forwarded, translated or not.
  logic unused_hit;
  assign unused_hit = hit;
  assign hit_eff    = 1'b1;
`endif

  assign addr_valid = s_ahb.hselx & s_ahb.hready & s_ahb.htrans[1];
  assign fwd_en     = s_ahb.hselx & s_ahb.hready & hit_eff;

  assign m_ahb.haddr     = haddr_xlat;
  assign m_ahb.htrans    = fwd_en ? s_ahb.htrans : HTRANS_IDLE;
  assign m_ahb.hsize     = s_ahb.hsize;
  assign m_ahb.hburst    = s_ahb.hburst;
  assign m_ahb.hprot     = s_ahb.hprot;
  assign m_ahb.hwrite    = s_ahb.hwrite;
  assign m_ahb.hmastlock = s_ahb.hmastlock;
  assign m_ahb.hwdata    = s_ahb.hwdata;
  assign hrdata_fwd      = m_ahb.hrdata;

  always_comb begin
    addr_next = ST_IDLE;
    if (addr_valid) begin
      addr_next = hit_eff ? ST_FWD : ST_ERR1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    s_ahb.hreadyout = 1'b1;
    s_ahb.hresp     = 1'b0;
    s_ahb.hrdata    = '0;
    case (state_q)
      ST_IDLE: begin
        state_d = addr_next;
      end
      ST_FWD: begin
        s_ahb.hreadyout = m_ahb.hready;
        s_ahb.hresp     = m_ahb.hresp;
        s_ahb.hrdata    = hrdata_fwd;
        if (m_ahb.hready) begin
          state_d = addr_next;
        end
      end
      ST_ERR1: begin
        s_ahb.hreadyout = 1'b0;
        s_ahb.hresp     = 1'b1;
        state_d         = ST_ERR2;
      end
      ST_ERR2: begin
        s_ahb.hresp = 1'b1;
        state_d     = addr_next;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_remap_win.sv
// tb_ahb_remap_win: self-checking bench for ahb_remap_win against a transaction-level reference model.
// Expectations follow AHB_REMAP_WIN_DECERR_EN the same way the design does.
`timescale 1ns/1ps
module tb_ahb_remap_win;
  import ahb_remap_pkg::*;

  localparam int DW = 32;
`ifdef AHB_REMAP_WIN_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  localparam logic [63:0] P_BASE = {32'h0100_0000, 32'h0000_0000};
  localparam logic [63:0] P_MASK = {32'hFF00_0000, 32'hFF00_0000};
  localparam logic [63:0] P_XLAT = {32'h4000_0000, 32'h2000_0000};
  localparam logic [63:0] O_BASE = {32'h0000_0000, 32'h0000_0000};
  localparam logic [63:0] O_MASK = {32'hFF00_0000, 32'hF000_0000};
  localparam logic [63:0] O_XLAT = {32'h5000_0000, 32'h3000_0000};

  typedef logic [31:0] win_t [2];
  // window lists, index 0 first
  win_t main_base = '{32'h0000_0000, 32'h0100_0000};
  win_t main_mask = '{32'hFF00_0000, 32'hFF00_0000};
  win_t main_xlat = '{32'h2000_0000, 32'h4000_0000};
  win_t ovl_base  = '{32'h0000_0000, 32'h0000_0000};
  win_t ovl_mask  = '{32'hF000_0000, 32'hFF00_0000};
  win_t ovl_xlat  = '{32'h3000_0000, 32'h5000_0000};

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_remap_win_if #(.DW(DW)) s_bus ();
  ahb_remap_win_if #(.DW(DW)) m_bus ();
  ahb_remap_win_if #(.DW(DW)) o_s ();
  ahb_remap_win_if #(.DW(DW)) o_m ();

  ahb_remap_win #(
    .NWIN(2), .DW(DW), .WIN_BASE(P_BASE), .WIN_MASK(P_MASK), .WIN_XLAT(P_XLAT)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .s_ahb(s_bus), .m_ahb(m_bus)
  );

  ahb_remap_win #(
    .NWIN(2), .DW(DW), .WIN_BASE(O_BASE), .WIN_MASK(O_MASK), .WIN_XLAT(O_XLAT)
  ) dut_ovl (
    .hclk(hclk), .hresetn(hresetn), .s_ahb(o_s), .m_ahb(o_m)
  );

  int checks = 0;
  int errors = 0;

  typedef enum {DP_NONE, DP_FWD, DP_ERR} dp_t;
  dp_t dp_kind = DP_NONE;
  int  err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First matching window in list order translates; returns {hit, address}.
  function automatic logic [32:0] ref_xlat(input win_t base, input win_t mask,
                                           input win_t xlat, input logic [31:0] a);
    for (int i = 0; i < 2; i++) begin
      if ((a & mask[i]) == (base[i] & mask[i]))
        return {1'b1, (a & ~mask[i]) | (xlat[i] & mask[i])};
    end
    return {1'b0, a};
  endfunction

  task automatic drive_idle();
    s_bus.haddr = '0; s_bus.hsize = '0; s_bus.hburst = '0; s_bus.hprot = '0;
    s_bus.htrans = HTRANS_IDLE; s_bus.hwrite = 1'b0; s_bus.hmastlock = 1'b0;
    s_bus.hready = 1'b1; s_bus.hselx = 1'b0; s_bus.hwdata = '0;
  endtask

  // One bus cycle, entered at posedge+1: drive, check at +2, advance the model, return at next posedge+1.
  task automatic cycle(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic mrdy, input logic mresp,
                       input logic [DW-1:0] mrdata);
    logic          e_rdy, e_resp, e_hit, e_fwd;
    logic [DW-1:0] e_rdata;
    logic [31:0]   e_addr;
    logic [1:0]    e_tr;
    logic [32:0]   xr;
    logic [1:0]    hs;
    logic [2:0]    hb;
    logic [3:0]    hp;
    logic          lk;
    logic [31:0]   wd;
    e_rdy = 1'b1; e_resp = 1'b0; e_rdata = '0;
    if (dp_kind == DP_FWD) begin
      e_rdy = mrdy; e_resp = mresp; e_rdata = mrdata;
    end else if (dp_kind == DP_ERR) begin
      e_rdy = (err_cnt == 1); e_resp = 1'b1;
    end
    xr     = ref_xlat(main_base, main_mask, main_xlat, addr);
    e_hit  = xr[32];
    e_addr = xr[31:0];
    e_fwd  = sel && e_rdy && (e_hit || !DECERR);
    e_tr   = e_fwd ? tr : 2'b00;
    hs = 2'($urandom_range(0, 3)); hb = 3'($urandom_range(0, 7));
    hp = 4'($urandom_range(0, 15)); lk = 1'($urandom_range(0, 1)); wd = $urandom;
    s_bus.haddr = addr; s_bus.htrans = tr; s_bus.hselx = sel; s_bus.hready = e_rdy;
    s_bus.hwrite = wr; s_bus.hsize = hs; s_bus.hburst = hb; s_bus.hprot = hp;
    s_bus.hmastlock = lk; s_bus.hwdata = wd;
    m_bus.hready = mrdy; m_bus.hresp = mresp; m_bus.hrdata = mrdata;
    #1;
    check("hreadyout", s_bus.hreadyout, e_rdy);
    check("hresp", s_bus.hresp, e_resp);
    check("hrdata", s_bus.hrdata, e_rdata);
    check("m_htrans", m_bus.htrans, e_tr);
    check("m_haddr", m_bus.haddr, e_addr);
    check("m_ctrl", {m_bus.hsize, m_bus.hburst, m_bus.hprot, m_bus.hwrite, m_bus.hmastlock, m_bus.hwdata},
          {hs, hb, hp, wr, lk, wd});
    if (dp_kind == DP_ERR && err_cnt == 0) begin
      err_cnt = 1;
    end else if (e_rdy) begin
      if (sel && tr[1]) begin
        if (e_hit || !DECERR) dp_kind = DP_FWD;
        else begin dp_kind = DP_ERR; err_cnt = 0; end
      end else begin
        dp_kind = DP_NONE;
      end
    end
    @(posedge hclk); #1;
  endtask

  task automatic idle_cycle(input logic mrdy, input logic [DW-1:0] mrdata);
    cycle(1'b0, HTRANS_IDLE, 32'h0, 1'b0, mrdy, 1'b0, mrdata);
  endtask

  initial begin
    logic [32:0] xr;
    logic [31:0] ovl_addrs [3];
    logic [31:0] a;
    hresetn = 1'b0;
    drive_idle();
    m_bus.hrdata = 32'hDEAD_BEEF; m_bus.hresp = 1'b1; m_bus.hready = 1'b0;
    m_bus.hselx = 1'b0; m_bus.hreadyout = 1'b1;
    o_s.haddr = '0; o_s.hsize = '0; o_s.hburst = '0; o_s.hprot = '0; o_s.htrans = HTRANS_NONSEQ;
    o_s.hwrite = 1'b0; o_s.hmastlock = 1'b0; o_s.hready = 1'b1; o_s.hselx = 1'b1; o_s.hwdata = '0;
    o_m.hrdata = '0; o_m.hresp = 1'b0; o_m.hready = 1'b1; o_m.hselx = 1'b0; o_m.hreadyout = 1'b1;

    // reset state
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hreadyout", s_bus.hreadyout, 1'b1);
    check("rst_hresp", s_bus.hresp, 1'b0);
    check("rst_hrdata", s_bus.hrdata, '0);
    check("rst_m_htrans", m_bus.htrans, 2'b00);
    s_bus.hselx = 1'b1; s_bus.htrans = HTRANS_NONSEQ; s_bus.haddr = 32'h0000_1234;
    #1;
    check("rst_gate_htrans", m_bus.htrans, 2'b10);
    drive_idle();
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    dp_kind = DP_NONE;

    // basic hit, then wait-stated read
    cycle(1'b1, HTRANS_NONSEQ, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 32'h0);
    idle_cycle(1'b1, 32'h1111_2222);
    cycle(1'b1, HTRANS_NONSEQ, 32'h01AB_CDEF, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) idle_cycle(1'b0, 32'h0BAD_0BAD);
    idle_cycle(1'b1, 32'hCAFE_F00D);

    // miss
    cycle(1'b1, HTRANS_NONSEQ, 32'h7700_0000, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) idle_cycle(1'b1, 32'h5555_AAAA);

    // hit, miss in its data phase, hit held through ERR1 and accepted in ERR2
    cycle(1'b1, HTRANS_NONSEQ, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, HTRANS_NONSEQ, 32'h7700_0010, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    cycle(1'b1, HTRANS_NONSEQ, 32'h0100_0020, 1'b0, 1'b1, 1'b0, 32'h2222_3333);
    cycle(1'b1, HTRANS_NONSEQ, 32'h0100_0020, 1'b0, 1'b1, 1'b0, 32'h4444_5555);
    idle_cycle(1'b1, 32'h6666_7777);
    idle_cycle(1'b1, 32'h0);

    // miss access that is forwarded untranslated when local error decode is absent
    cycle(1'b1, HTRANS_NONSEQ, 32'h7700_0010, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) idle_cycle(1'b1, 32'h8888_9999);

    // reset in the middle of a stalled forwarded data phase
    cycle(1'b1, HTRANS_NONSEQ, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0);
    drive_idle();
    s_bus.hready = 1'b0; m_bus.hready = 1'b0; m_bus.hresp = 1'b0; m_bus.hrdata = 32'h1357_9BDF;
    #1;
    check("stall_pre_rst", s_bus.hreadyout, 1'b0);
    hresetn = 1'b0;
    #1;
    check("abort_hreadyout", s_bus.hreadyout, 1'b1);
    check("abort_hresp", s_bus.hresp, 1'b0);
    check("abort_hrdata", s_bus.hrdata, '0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    dp_kind = DP_NONE;
    idle_cycle(1'b1, 32'h2468_ACE0);

    // overlapping windows: window 0 takes priority
    ovl_addrs[0] = 32'h00AB_CDEF;
    ovl_addrs[1] = 32'h0123_4567;
    ovl_addrs[2] = 32'h1000_0000;
    for (int k = 0; k < 3; k++) begin
      o_s.haddr = ovl_addrs[k];
      #1;
      xr = ref_xlat(ovl_base, ovl_mask, ovl_xlat, ovl_addrs[k]);
      check("ovl_m_haddr", o_m.haddr, xr[31:0]);
      check("ovl_m_htrans", o_m.htrans, (xr[32] || !DECERR) ? 2'b10 : 2'b00);
    end
    check("ovl_w0_const", {31'h0, ref_xlat(ovl_base, ovl_mask, ovl_xlat, 32'h00AB_CDEF)},
          {31'h0, 1'b1, 32'h30AB_CDEF});
    @(posedge hclk); #1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       a = {8'h00, 24'($urandom)};
        1:       a = {8'h01, 24'($urandom)};
        default: a = $urandom;
      endcase
      cycle(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), $urandom);
    end
    repeat (3) idle_cycle(1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
